controlador_travessia: RTL and testbench
========================================

# controlador_travessia

Phase scheduler for a two-road intersection with a shared pedestrian crossing. It sequences the green/yellow/red lamps of roads A and B through fixed phases and all-red clearances. It latches pedestrian button presses, shortens the running green to serve them, and inserts an all-red walk phase. It also supports the day/night (flashing yellow) mode used by the existing traffic-light controller.

## Interface
- T_VERDE, 4: green duration per road, cycles (1..15)
- T_MIN, 2: minimum green before a pending pedestrian request may cut it (1..T_VERDE)
- T_AMARELO, 1: yellow duration, cycles (1..15)
- T_VERMELHO, 1: all-red clearance duration, cycles (1..15)
- T_PED, 3: pedestrian walk duration, cycles (1..15)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- modo  in  1  0 = day sequencing, 1 = night flashing
- botao  in  1  pedestrian button, level, sampled every edge
- verdeA, amareloA, vermelhoA  out  1 each  road A lamps
- verdeB, amareloB, vermelhoB  out  1 each  road B lamps
- travessia  out  1  pedestrian walk lamp
- ped_pendente  out  1  registered pedestrian request latch

## Operation
- States:
  - VERDE_A: A green, B red.
  - AMARELO_A: A yellow, B red.
  - VERM_AB: all red.
  - VERDE_B: A red, B green.
  - AMARELO_B: A red, B yellow.
  - VERM_BA: all red.
  - PED: all red, travessia=1.
  - NOITE0: both yellow.
  - NOITE1: all lamps off.
- Lamp outputs and travessia are a combinational decode of the state only. travessia=0 in every state except PED.
- Dwell counter cnt is 4-bit. It resets to 0 on every state change and otherwise increments. A state with duration N exits on the edge where cnt==N-1.
- Day transitions (modo=0):
  - VERDE_A→AMARELO_A→VERM_AB.
  - VERM_AB→PED if ped_pendente, else VERDE_B.
  - VERDE_B→AMARELO_B→VERM_BA.
  - VERM_BA→PED if ped_pendente, else VERDE_A.
  - PED→the green that would have followed. A 1-bit register proximo_b is set on leaving VERM_AB and cleared on leaving VERM_BA.
- Early cut: in VERDE_A/VERDE_B, the exit also occurs when ped_pendente==1 and cnt>=T_MIN-1.
- Request latch:
  - ped_pendente is set on an edge with botao=1, unless the state is PED, NOITE0 or NOITE1 (presses there are ignored).
  - It is cleared on the edge entering PED. A press on that same edge is absorbed, not re-latched.
- Night: modo=1 on any edge forces the next state to NOITE0 from any day state. It also clears ped_pendente and cnt.
- NOITE0 and NOITE1 alternate every cycle while modo=1.
- Night exit: modo=0 seen in NOITE0 or NOITE1 goes to VERM_BA (full T_VERMELHO), then to VERDE_A. proximo_b is cleared on night entry.

## Timing
- Reset (asynchronous assert, any time, including mid-phase or mid-walk):
  - state=VERDE_A, cnt=0, proximo_b=0, ped_pendente=0.
  - Outputs: verdeA=1, vermelhoB=1, all other lamps 0, travessia=0.
- First edge after reset release counts as cnt 0→1. VERDE_A lasts exactly T_VERDE edges.
- Undisturbed day cycle = 2·(T_VERDE+T_AMARELO+T_VERMELHO) = 12 cycles at defaults.
- Latency from press to latch: 1 edge. ped_pendente is visible the cycle after botao is sampled high.
- Simultaneous modo=1 and botao=1: night wins, and no request is latched.
- An early cut never shortens green below T_MIN cycles. Yellow and all-red are never shortened.
- Illegal state encodings recover to VERDE_A on the next edge.

## Test plan
- Reset, modo=0, botao=0 for 24 cycles → verdeA high for cycles 0–3, amareloA at 4, all-red at 5, verdeB at 6–9, amareloB at 10, all-red at 11; the pattern repeats at cycle 12.
- Pulse botao for 1 cycle at VERDE_A cnt=0 → ped_pendente=1 next cycle. VERDE_A ends after 2 cycles, then AMARELO_A 1, VERM_AB 1, PED 3 (travessia=1, ped_pendente=0), then VERDE_B.
- Hold botao high through PED → no re-latch during PED. ped_pendente becomes 1 on the first edge after PED, and the following green is cut at 2 cycles.
- modo=1 during VERDE_B cnt=2 → NOITE0 next cycle, then NOITE1/NOITE0 alternate. modo=0 → VERM_BA for 1 cycle, then VERDE_A with cnt=0.
- botao pulsed during night → ignored; ped_pendente stays 0 after returning to day.
- Assert reset mid-PED (cnt=1) → immediately VERDE_A lamps, travessia=0, ped_pendente=0. After release, the normal 12-cycle sequence resumes.

Source files
------------

// File: rtl/controlador_travessia.sv
// Phase scheduler for a two-road intersection with a shared pedestrian crossing.
// Day sequencing with pedestrian early cut and walk phase, plus night flashing.
module controlador_travessia #(
  parameter int T_VERDE    = 4,
  parameter int T_MIN      = 2,
  parameter int T_AMARELO  = 1,
  parameter int T_VERMELHO = 1,
  parameter int T_PED      = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_modo,
  input  logic i_botao,
  output logic o_verdeA,
  output logic o_amareloA,
  output logic o_vermelhoA,
  output logic o_verdeB,
  output logic o_amareloB,
  output logic o_vermelhoB,
  output logic o_travessia,
  output logic o_ped_pendente
);

  typedef enum logic [3:0] {
    VERDE_A   = 4'd0,
    AMARELO_A = 4'd1,
    VERM_AB   = 4'd2,
    VERDE_B   = 4'd3,
    AMARELO_B = 4'd4,
    VERM_BA   = 4'd5,
    PED       = 4'd6,
    NOITE0    = 4'd7,
    NOITE1    = 4'd8
  } state_t;

  localparam logic [3:0] C_VERDE    = 4'(T_VERDE - 1);
  localparam logic [3:0] C_MIN      = 4'(T_MIN - 1);
  localparam logic [3:0] C_AMARELO  = 4'(T_AMARELO - 1);
  localparam logic [3:0] C_VERMELHO = 4'(T_VERMELHO - 1);
  localparam logic [3:0] C_PED      = 4'(T_PED - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       r_proximo_b;
  logic       r_ped_pendente;

  logic w_corte;
  logic w_fim_verde;
  logic w_fim_amarelo;
  logic w_fim_vermelho;
  logic w_fim_ped;
  logic w_muda;
  logic w_aceita;
  logic w_entra_ped;

  // A pending request may cut the green only after the minimum green elapsed.
  assign w_corte        = r_ped_pendente && (r_cnt >= C_MIN);
  assign w_fim_verde    = (r_cnt == C_VERDE) || w_corte;
  assign w_fim_amarelo  = (r_cnt == C_AMARELO);
  assign w_fim_vermelho = (r_cnt == C_VERMELHO);
  assign w_fim_ped      = (r_cnt == C_PED);
  assign w_muda         = (w_next != r_state);
  assign w_entra_ped    = (w_next == PED) && (r_state != PED);

  always_comb begin
    w_aceita = 1'b0;
    case (r_state)
      VERDE_A, AMARELO_A, VERM_AB,
      VERDE_B, AMARELO_B, VERM_BA: w_aceita = 1'b1;
      default:                     w_aceita = 1'b0;
    endcase
  end

  always_comb begin
    w_next = VERDE_A;
    if (i_modo) begin
      case (r_state)
        NOITE0:  w_next = NOITE1;
        VERDE_A, AMARELO_A, VERM_AB, VERDE_B,
        AMARELO_B, VERM_BA, PED, NOITE1:
                 w_next = NOITE0;
        default: w_next = VERDE_A;
      endcase
    end else begin
      case (r_state)
        VERDE_A:   w_next = w_fim_verde ? AMARELO_A : VERDE_A;
        AMARELO_A: w_next = w_fim_amarelo ? VERM_AB : AMARELO_A;
        VERM_AB: begin
          if (w_fim_vermelho) w_next = r_ped_pendente ? PED : VERDE_B;
          else                w_next = VERM_AB;
        end
        VERDE_B:   w_next = w_fim_verde ? AMARELO_B : VERDE_B;
        AMARELO_B: w_next = w_fim_amarelo ? VERM_BA : AMARELO_B;
        VERM_BA: begin
          if (w_fim_vermelho) w_next = r_ped_pendente ? PED : VERDE_A;
          else                w_next = VERM_BA;
        end
        PED: begin
          if (w_fim_ped) w_next = r_proximo_b ? VERDE_B : VERDE_A;
          else           w_next = PED;
        end
        // Leaving night always passes through a full all-red before road A.
        NOITE0, NOITE1: w_next = VERM_BA;
        default:        w_next = VERDE_A;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= VERDE_A;
      r_cnt          <= 4'd0;
      r_proximo_b    <= 1'b0;
      r_ped_pendente <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_muda || i_modo) r_cnt <= 4'd0;
      else                  r_cnt <= r_cnt + 4'd1;

      if (i_modo)                           r_proximo_b <= 1'b0;
      else if ((r_state == VERM_AB) && w_muda) r_proximo_b <= 1'b1;
      else if ((r_state == VERM_BA) && w_muda) r_proximo_b <= 1'b0;

      // Entering the walk clears the latch even if the button is still held.
      if (i_modo)                    r_ped_pendente <= 1'b0;
      else if (w_entra_ped)          r_ped_pendente <= 1'b0;
      else if (i_botao && w_aceita)  r_ped_pendente <= 1'b1;
    end
  end

  always_comb begin
    o_verdeA    = 1'b0;
    o_amareloA  = 1'b0;
    o_vermelhoA = 1'b0;
    o_verdeB    = 1'b0;
    o_amareloB  = 1'b0;
    o_vermelhoB = 1'b0;
    o_travessia = 1'b0;
    case (r_state)
      VERDE_A: begin
        o_verdeA    = 1'b1;
        o_vermelhoB = 1'b1;
      end
      AMARELO_A: begin
        o_amareloA  = 1'b1;
        o_vermelhoB = 1'b1;
      end
      VERDE_B: begin
        o_vermelhoA = 1'b1;
        o_verdeB    = 1'b1;
      end
      AMARELO_B: begin
        o_vermelhoA = 1'b1;
        o_amareloB  = 1'b1;
      end
      PED: begin
        o_vermelhoA = 1'b1;
        o_vermelhoB = 1'b1;
        o_travessia = 1'b1;
      end
      NOITE0: begin
        o_amareloA = 1'b1;
        o_amareloB = 1'b1;
      end
      NOITE1: begin
      end
      default: begin
        o_vermelhoA = 1'b1;
        o_vermelhoB = 1'b1;
      end
    endcase
  end

  assign o_ped_pendente = r_ped_pendente;

endmodule

// File: tb/tb_controlador_travessia.sv
// Self-checking bench for controlador_travessia: directed test-plan steps followed
// by randomized traffic, all compared against a phase/elapsed-time reference model.
module tb_controlador_travessia;

  localparam int T_VERDE    = 4;
  localparam int T_MIN      = 2;
  localparam int T_AMARELO  = 1;
  localparam int T_VERMELHO = 1;
  localparam int T_PED      = 3;

  localparam int P_VA  = 0;
  localparam int P_AA  = 1;
  localparam int P_RAB = 2;
  localparam int P_VB  = 3;
  localparam int P_AB  = 4;
  localparam int P_RBA = 5;
  localparam int P_PED = 6;
  localparam int P_N0  = 7;
  localparam int P_N1  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic modo  = 1'b0;
  logic botao = 1'b0;
  logic verdeA, amareloA, vermelhoA, verdeB, amareloB, vermelhoB, travessia, ped_pendente;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: current phase, cycles spent in it, request latch, next-road flag.
  int ph;
  int el;
  bit m_ped;
  bit m_nb;

  logic [6:0] lamp_tab [0:8];
  int         dur_tab  [0:8];
  int         pat      [0:11];

  controlador_travessia #(
    .T_VERDE(T_VERDE), .T_MIN(T_MIN), .T_AMARELO(T_AMARELO),
    .T_VERMELHO(T_VERMELHO), .T_PED(T_PED)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_modo(modo), .i_botao(botao),
    .o_verdeA(verdeA), .o_amareloA(amareloA), .o_vermelhoA(vermelhoA),
    .o_verdeB(verdeB), .o_amareloB(amareloB), .o_vermelhoB(vermelhoB),
    .o_travessia(travessia), .o_ped_pendente(ped_pendente)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    ph = P_VA; el = 0; m_ped = 1'b0; m_nb = 1'b0;
  endtask

  task automatic model_step(input logic m, input logic b);
    int  nxt;
    bit  np;
    bit  nb;
    bit  done;
    nxt  = ph;
    np   = m_ped;
    nb   = m_nb;
    done = (el + 1 >= dur_tab[ph]);
    if (m) begin
      np  = 1'b0;
      nb  = 1'b0;
      nxt = (ph == P_N0) ? P_N1 : P_N0;
    end else begin
      if (b && !(ph inside {P_PED, P_N0, P_N1})) np = 1'b1;
      case (ph)
        P_VA:  if (done || (m_ped && el + 1 >= T_MIN)) nxt = P_AA;
        P_AA:  if (done) nxt = P_RAB;
        P_RAB: if (done) begin nb = 1'b1; nxt = m_ped ? P_PED : P_VB; end
        P_VB:  if (done || (m_ped && el + 1 >= T_MIN)) nxt = P_AB;
        P_AB:  if (done) nxt = P_RBA;
        P_RBA: if (done) begin nb = 1'b0; nxt = m_ped ? P_PED : P_VA; end
        P_PED: if (done) nxt = m_nb ? P_VB : P_VA;
        default: nxt = P_RBA;
      endcase
      if (nxt == P_PED) np = 1'b0;
    end
    el    = (nxt != ph) ? 0 : el + 1;
    ph    = nxt;
    m_ped = np;
    m_nb  = nb;
  endtask

  task automatic check(input string tag);
    logic [7:0] obs;
    logic [7:0] want;
    obs  = {verdeA, amareloA, vermelhoA, verdeB, amareloB, vermelhoB, travessia, ped_pendente};
    want = {lamp_tab[ph], m_ped};
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (phase %0d elapsed %0d)", tag, obs, want, ph, el);
    end
  endtask

  task automatic check_lamps(input string tag, input logic [6:0] want);
    logic [6:0] obs;
    obs = {verdeA, amareloA, vermelhoA, verdeB, amareloB, vermelhoB, travessia};
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed lamps %b expected %b", tag, obs, want);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick(input logic m, input logic b, input string tag);
    modo  = m;
    botao = b;
    @(posedge clk);
    model_step(m, b);
    #1;
    check(tag);
  endtask

  task automatic run_pattern(input string tag);
    for (int k = 1; k <= 24; k++) begin
      tick(1'b0, 1'b0, tag);
      check_lamps(tag, lamp_tab[pat[k % 12]]);
    end
  endtask

  task automatic advance_to(input int tp, input int te, input logic b);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (ph == tp && el == te) found = 1'b1;
      else tick(1'b0, b, "advance");
    end
    check_int("advance_reached", int'(found), 1);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check(tag);
    @(posedge clk);
    #1;
    check(tag);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int   ntrav;
    logic rm;
    logic rb;

    lamp_tab[P_VA]  = 7'b1000010;
    lamp_tab[P_AA]  = 7'b0100010;
    lamp_tab[P_RAB] = 7'b0010010;
    lamp_tab[P_VB]  = 7'b0011000;
    lamp_tab[P_AB]  = 7'b0010100;
    lamp_tab[P_RBA] = 7'b0010010;
    lamp_tab[P_PED] = 7'b0010011;
    lamp_tab[P_N0]  = 7'b0100100;
    lamp_tab[P_N1]  = 7'b0000000;
    dur_tab[P_VA]  = T_VERDE;    dur_tab[P_AA]  = T_AMARELO; dur_tab[P_RAB] = T_VERMELHO;
    dur_tab[P_VB]  = T_VERDE;    dur_tab[P_AB]  = T_AMARELO; dur_tab[P_RBA] = T_VERMELHO;
    dur_tab[P_PED] = T_PED;      dur_tab[P_N0]  = 1;         dur_tab[P_N1]  = 1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4)       pat[c] = P_VA;
      else if (c == 4) pat[c] = P_AA;
      else if (c == 5) pat[c] = P_RAB;
      else if (c < 10) pat[c] = P_VB;
      else if (c == 10) pat[c] = P_AB;
      else             pat[c] = P_RBA;
    end

    // Reset state
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset");
    check_lamps("reset_lamps", 7'b1000010);
    #11 rst_n = 1'b1;

    // Undisturbed day cycle, two full periods
    run_pattern("day_cycle");

    // Single press at VERDE_A cnt=0: short green, walk, then road B
    tick(1'b0, 1'b1, "press");
    check_int("ped_latched", int'(ped_pendente), 1);
    ntrav = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, "press_seq");
      if (travessia) ntrav++;
    end
    check_int("walk_cycles", ntrav, T_PED);
    check_lamps("after_walk_green_b", 7'b0011000);

    // Button held through a walk phase, then released
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, "hold");
    for (int i = 0; i < 14; i++) tick(1'b0, 1'b0, "hold_release");

    // Night entry from VERDE_B cnt=2, presses during night, exit
    advance_to(P_VB, 2, 1'b0);
    tick(1'b1, 1'b0, "night_entry");
    check_lamps("night0", 7'b0100100);
    for (int i = 0; i < 6; i++) tick(1'b1, logic'(i % 2), "night_alt");
    tick(1'b0, 1'b0, "night_exit");
    check_lamps("night_exit_allred", 7'b0010010);
    tick(1'b0, 1'b0, "night_to_green");
    check_lamps("night_green_a", 7'b1000010);
    check_int("night_no_request", int'(ped_pendente), 0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, "post_night");

    // Asynchronous reset in the middle of a walk
    tick(1'b0, 1'b1, "press2");
    advance_to(P_PED, 1, 1'b0);
    check_int("in_walk", int'(travessia), 1);
    async_reset("reset_mid_ped");
    run_pattern("after_reset");

    // Randomized traffic with occasional night periods and resets
    rm = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) rm = ~rm;
      rb = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 249) == 0) async_reset("random_reset");
      else tick(rm, rb, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
